// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: owns the PC, fetches from async instruction memory into IF/ID,
// handles redirects, stalls, PAUSE back-off and ECALL/EBREAK halt.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int PAUSE_CYCLES = 8,
   parameter int IMEM_AW = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [IMEM_AW-1:0]   imem_addr,
   input  logic [31:0]          imem_data,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   input  logic                 resume,
   output logic [31:0]          pc,
   output logic                 if_id_valid,
   output logic [31:0]          if_id_instr,
   output logic [31:0]          if_id_pc,
   output logic [31:0]          if_id_pc_plus4,
   output logic                 halted
);
   localparam int CW = PAUSE_CYCLES > 0 ? $clog2(PAUSE_CYCLES + 1) : 1;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] PAUSE_OP = 32'h0100_000F;
   typedef enum logic [1:0] {RUN, PAUSE, HALT} state_t;
   state_t state;
   logic [CW-1:0] pause_cnt;
   logic [CW-1:0] cnt_dec;
   logic [31:0] pc_plus4;
   logic halt_op;
   logic pause_op;
   assign imem_addr = pc[IMEM_AW+1:2];
   assign pc_plus4 = pc + 32'd4;
   assign halt_op = imem_data == ECALL || imem_data == EBREAK;
   assign pause_op = imem_data == PAUSE_OP && PAUSE_CYCLES > 0;
   // counter saturates so a long stall cannot wrap it; exit then happens on the first free edge
   assign cnt_dec = pause_cnt == '0 ? '0 : pause_cnt - CW'(1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
         state <= RUN;
         pause_cnt <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc <= '0;
         if_id_pc_plus4 <= '0;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         pc <= {redirect_pc[31:2], 2'b00};
         if_id_valid <= 1'b0;
         state <= RUN;
         pause_cnt <= '0;
         halted <= 1'b0;
      end else begin
         if (state == PAUSE) pause_cnt <= cnt_dec;
         if (!stall) begin
            case (state)
               RUN: begin
                  if_id_valid <= 1'b1;
                  if_id_instr <= imem_data;
                  if_id_pc <= pc;
                  if_id_pc_plus4 <= pc_plus4;
                  pc <= pc_plus4;
                  if (halt_op) begin
                     state <= HALT;
                     halted <= 1'b1;
                  end else if (pause_op) begin
                     state <= PAUSE;
                     pause_cnt <= CW'(PAUSE_CYCLES);
                  end
               end
               PAUSE: begin
                  if_id_valid <= 1'b0;
                  if (pause_cnt <= CW'(1)) state <= RUN;
               end
               default: begin
                  if_id_valid <= 1'b0;
                  if (resume) begin
                     state <= RUN;
                     halted <= 1'b0;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed test-plan steps then random traffic, all against a behavioural model.
module tb_instr_fetch_stage;
   localparam int PC_N = 8;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] PAUSE_OP = 32'h0100_000F;
   localparam logic [31:0] FENCE_TSO = 32'h8330_000F;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic resume = 1'b0;
   logic [5:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc;
   logic if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic halted;
   logic [31:0] mem [64];
   int checks = 0;
   int failures = 0;
   logic [31:0] m_pc, m_i, m_ip, m_ip4;
   logic m_v, m_h, m_p;
   int m_left;

   instr_fetch_stage #(.RESET_PC(32'h0), .PAUSE_CYCLES(PC_N), .IMEM_AW(6)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .resume(resume), .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .halted(halted)
   );

   assign imem_data = mem[imem_addr];
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // model: one clock edge of the fetch stage, described by its observable rules
   task automatic tick();
      logic [31:0] ins;
      ins = mem[m_pc[7:2]];
      if (!rst_n) begin
         m_pc = 32'h0; m_v = 0; m_i = 0; m_ip = 0; m_ip4 = 0; m_h = 0; m_p = 0; m_left = 0;
      end else if (redirect_valid) begin
         m_pc = redirect_pc & ~32'd3; m_v = 0; m_h = 0; m_p = 0; m_left = 0;
      end else if (stall) begin
         if (m_p && m_left > 0) m_left--;
      end else if (m_h) begin
         m_v = 0;
         if (resume) m_h = 0;
      end else if (m_p) begin
         m_v = 0;
         if (m_left <= 1) m_p = 0;
         if (m_left > 0) m_left--;
      end else begin
         m_v = 1; m_i = ins; m_ip = m_pc; m_ip4 = m_pc + 4; m_pc = m_pc + 4;
         if (ins == ECALL || ins == EBREAK) m_h = 1;
         else if (ins == PAUSE_OP && PC_N > 0) begin m_p = 1; m_left = PC_N; end
      end
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[7:2]));
      chk("valid", 32'(if_id_valid), 32'(m_v));
      chk("instr", if_id_instr, m_i);
      chk("if_id_pc", if_id_pc, m_ip);
      chk("pc_plus4", if_id_pc_plus4, m_ip4);
      chk("halted", 32'(halted), 32'(m_h));
   endtask

   task automatic redir(input logic [31:0] t);
      redirect_valid = 1; redirect_pc = t;
      tick();
      redirect_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      mem[0] = 32'h0050_0113;
      mem[1] = 32'h0070_0193;
      mem[2] = 32'h0000_0463;
      mem[3] = PAUSE_OP;
      mem[7] = EBREAK;
      m_pc = 0; m_v = 0; m_i = 0; m_ip = 0; m_ip4 = 0; m_h = 0; m_p = 0; m_left = 0;
      tick(); tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      rst_n = 1;
      tick();
      chk("first_pc", if_id_pc, 32'h0);
      chk("first_instr", if_id_instr, 32'h0050_0113);
      chk("first_valid", 32'(if_id_valid), 32'h1);
      chk("first_addr", 32'(imem_addr), 32'h1);
      tick();
      chk("second_pc", if_id_pc, 32'h4);
      chk("second_p4", if_id_pc_plus4, 32'h8);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", pc, 32'h8);
         chk("stall_ifpc", if_id_pc, 32'h4);
      end
      stall = 0;
      tick();
      chk("post_stall_ifpc", if_id_pc, 32'h8);
      chk("post_stall_pc", pc, 32'hC);
      redir(32'h10);
      chk("redir_pc", pc, 32'h10);
      chk("redir_valid", 32'(if_id_valid), 32'h0);
      stall = 1;
      redir(32'h12);
      stall = 0;
      chk("misaligned_redir", pc, 32'h10);
      for (int i = 0; i < 4; i++) tick();
      chk("ebreak_ifpc", if_id_pc, 32'h1C);
      chk("ebreak_halted", 32'(halted), 32'h1);
      chk("ebreak_pc", pc, 32'h20);
      tick(); tick();
      chk("halt_hold_pc", pc, 32'h20);
      chk("halt_bubble", 32'(if_id_valid), 32'h0);
      resume = 1; tick(); resume = 0;
      chk("resume_halted", 32'(halted), 32'h0);
      tick();
      chk("resume_fetch", if_id_pc, 32'h20);
      redir(32'hC);
      tick();
      chk("pause_captured", if_id_instr, PAUSE_OP);
      for (int i = 0; i < PC_N; i++) begin
         tick();
         chk("pause_bubble", 32'(if_id_valid), 32'h0);
      end
      tick();
      chk("pause_exit", if_id_pc, 32'h10);
      chk("pause_exit_valid", 32'(if_id_valid), 32'h1);
      redir(32'hC);
      tick(); tick(); tick(); tick();
      redir(32'h0);
      chk("mid_pause_redir", pc, 32'h0);
      tick();
      chk("mid_pause_fetch", if_id_pc, 32'h0);
      mem[7] = ECALL;
      redir(32'h1C);
      tick();
      chk("ecall_halted", 32'(halted), 32'h1);
      tick();
      resume = 1; tick(); resume = 0;
      tick();
      chk("ecall_resume", if_id_pc, 32'h20);
      redir(32'h1C);
      tick();
      rst_n = 0; tick(); rst_n = 1;
      chk("halt_rst_pc", pc, 32'h0);
      chk("halt_rst_halted", 32'(halted), 32'h0);
      mem[7] = FENCE_TSO;
      redir(32'h1C);
      tick();
      chk("fence_nohalt", 32'(halted), 32'h0);
      tick();
      chk("fence_nopause", 32'(if_id_valid), 32'h1);
      for (int i = 0; i < 55; i++) tick();
      chk("wrap_pc", pc, 32'h100);
      chk("wrap_addr", 32'(imem_addr), 32'h0);
      tick();
      chk("wrap_fetch", if_id_instr, mem[0]);
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(0, 19))
            0: mem[i] = EBREAK;
            1: mem[i] = ECALL;
            2, 3: mem[i] = PAUSE_OP;
            4: mem[i] = FENCE_TSO;
            default: mem[i] = $urandom;
         endcase
      end
      for (int i = 0; i < 3000; i++) begin
         rst_n = $urandom_range(0, 99) != 0;
         stall = $urandom_range(0, 3) == 0;
         redirect_valid = $urandom_range(0, 15) == 0;
         redirect_pc = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 300));
         resume = $urandom_range(0, 3) == 0;
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
